// File: rtl/sum_link_pkg.sv
// Shared definitions for both ends of the inter-core partial-sum link.
// The transmitter and receiver use the same widths, the same depth and
// the same receive FSM encoding.
package sum_link_pkg;

  localparam int BW_PSUM    = 20;
  localparam int SUM_W      = BW_PSUM + 4;
  localparam int LINK_DEPTH = 8;
  localparam int LINK_AW    = $clog2(LINK_DEPTH);

  // Receive-side pairing FSM: whether a local sum word is being held.
  typedef enum logic {
    NO_LOCAL = 1'b0,
    HOLD     = 1'b1
  } link_state_t;

endpackage

// File: rtl/sum_fifo.sv
// Synchronous FIFO that buffers peer sum words.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_push       write i_data this cycle. The caller must not push while
//                full unless it also pops in the same cycle.
//   i_pop        advance the read pointer. The caller must not pop while empty.
//   i_data       write data
//   o_data       FIFO head, valid whenever o_empty is 0
//   o_empty      registered count == 0
//   o_full       registered count == DEPTH
//   o_count      current occupancy
// A word written in cycle N appears at o_data in cycle N+1.
// There is no write-to-read bypass.
module sum_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage has no reset. The pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The pointers are exactly log2(DEPTH) bits wide, so they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/sum_link_rx.sv
// Receive end of the inter-core partial-sum link.
// Peer words are buffered in sum_fifo. Each peer word is paired with a
// local sum word, and the total is registered out to the SFP stage.
// One credit pulse goes back to the peer transmitter for every FIFO pop.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   rx_data/rx_valid        peer word and push request (credit-controlled)
//   rx_credit               one-cycle pulse per pop, registered
//   local_sum/local_valid   local core sum word
//   sfp_rd                  SFP can accept a combined total this cycle
//   sum_total/sum_valid     registered total and its one-cycle strobe
//   fifo_empty/fifo_full    FIFO status, derived from registered state
//   ovf_err/clr_err         sticky protocol error and its synchronous clear
//   dbg_state/dbg_count     FSM state and FIFO occupancy, for observation
// Handshake: a combine happens in the one cycle where the FIFO is non-empty,
// a local word is available (either held, or presented that cycle with
// local_valid), and sfp_rd is 1. That cycle pops the FIFO. sum_valid and
// rx_credit pulse in the following cycle. sfp_rd has no effect when no pair
// is available. rx_valid carries no ready signal back: the peer may send
// only while it holds a credit.
module sum_link_rx
  import sum_link_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [SUM_W-1:0]  rx_data,
  input  logic              rx_valid,
  output logic              rx_credit,
  input  logic [SUM_W-1:0]  local_sum,
  input  logic              local_valid,
  input  logic              sfp_rd,
  output logic [SUM_W-1:0]  sum_total,
  output logic              sum_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              ovf_err,
  input  logic              clr_err,
  output link_state_t       dbg_state,
  output logic [LINK_AW:0]  dbg_count
);

  link_state_t       r_state, w_next;
  logic [SUM_W-1:0]  r_local;
  logic [SUM_W-1:0]  r_sum_total;
  logic              r_sum_valid;
  logic              r_credit;
  logic              r_ovf;

  logic [SUM_W-1:0]  w_head;
  logic [SUM_W-1:0]  w_operand;
  logic              w_empty, w_full;
  logic              w_pop, w_push, w_drop;
  logic              w_latch, w_hold_err;

  // A push while full is allowed only when a pop frees a slot in the
  // same cycle. Otherwise the peer has broken its credit count.
  assign w_push = rx_valid && (!w_full || w_pop);
  assign w_drop = rx_valid && w_full && !w_pop;

  sum_fifo #(.W(SUM_W), .DEPTH(LINK_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (rx_data),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (dbg_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= NO_LOCAL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_latch    = 1'b0;
    w_hold_err = 1'b0;
    w_operand  = local_sum;
    case (r_state)
      NO_LOCAL: begin
        if (local_valid && !w_empty && sfp_rd) begin
          // The incoming local word bypasses local_reg.
          w_pop = 1'b1;
        end else if (local_valid) begin
          w_latch = 1'b1;
          w_next  = HOLD;
        end
      end
      HOLD: begin
        w_operand = r_local;
        if (!w_empty && sfp_rd) begin
          w_pop = 1'b1;
          if (local_valid) w_latch = 1'b1;
          else             w_next  = NO_LOCAL;
        end else if (local_valid) begin
          // The held word is lost. Overwrite it and flag the error.
          w_latch    = 1'b1;
          w_hold_err = 1'b1;
        end
      end
      default: w_next = NO_LOCAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_local     <= '0;
      r_sum_total <= '0;
      r_sum_valid <= 1'b0;
      r_credit    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_latch) r_local <= local_sum;
      // The add wraps modulo 2^SUM_W. The carry is discarded on purpose.
      if (w_pop)   r_sum_total <= w_operand + w_head;
      r_sum_valid <= w_pop;
      r_credit    <= w_pop;
      // A new error beats a clear in the same cycle.
      if (w_drop || w_hold_err) r_ovf <= 1'b1;
      else if (clr_err)         r_ovf <= 1'b0;
    end
  end

  assign rx_credit  = r_credit;
  assign sum_total  = r_sum_total;
  assign sum_valid  = r_sum_valid;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign ovf_err    = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sum_link_rx.sv
module tb_sum_link_rx;
  import sum_link_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [SUM_W-1:0]  rx_data;
  logic              rx_valid;
  logic              rx_credit;
  logic [SUM_W-1:0]  local_sum;
  logic              local_valid;
  logic              sfp_rd;
  logic [SUM_W-1:0]  sum_total;
  logic              sum_valid;
  logic              fifo_empty;
  logic              fifo_full;
  logic              ovf_err;
  logic              clr_err;
  link_state_t       dbg_state;
  logic [LINK_AW:0]  dbg_count;

  int checks   = 0;
  int failures = 0;
  int credits  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sum_link_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_credit   (rx_credit),
    .local_sum   (local_sum),
    .local_valid (local_valid),
    .sfp_rd      (sfp_rd),
    .sum_total   (sum_total),
    .sum_valid   (sum_valid),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .ovf_err     (ovf_err),
    .clr_err     (clr_err),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  // ---------------- vector table ----------------
  // Inputs are applied for one clock. Expected values are sampled 1 ns
  // after that edge.
  typedef struct {
    logic        rv;  logic [23:0] d;
    logic        lv;  logic [23:0] ls;
    logic        rd;  logic        clr;
    logic        sv;  logic [23:0] tot; logic cr;
    logic        emp; logic        full; logic ovf; logic st;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  // ---------------- scoreboard ----------------
  logic [SUM_W-1:0] exp_q[$];

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    rx_valid = 1'b0; rx_data = '0; local_valid = 1'b0; local_sum = '0;
    sfp_rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rx_credit === 1'b1) credits++;
  endtask

  task automatic drive(input logic rv, input logic [23:0] d, input logic lv,
                       input logic [23:0] ls, input logic rd, input logic clr);
    rx_valid = rv; rx_data = d; local_valid = lv; local_sum = ls;
    sfp_rd = rd; clr_err = clr;
  endtask

  initial begin
    // NO_LOCAL is 0, HOLD is 1.
    // basic pairing
    vecs[0]  = '{1'b1, 24'h000010, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 24'h0,      1'b1, 24'h000005, 1'b1, 1'b0, 1'b1, 24'h000015, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // local first, sfp_rd held high
    vecs[3]  = '{1'b0, 24'h0,      1'b1, 24'h000100, 1'b1, 1'b0, 1'b0, 24'h000015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h000015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h000015, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 24'h000001, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h000015, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 24'h000101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h000101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // overflow arithmetic
    vecs[9]  = '{1'b1, 24'h000002, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 24'h0,      1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // HOLD overwrite error, set beats clear, then clear
    vecs[12] = '{1'b0, 24'h0,      1'b1, 24'h000007, 1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 24'h0,      1'b1, 24'h000009, 1'b0, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 24'h000020, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 24'h000029, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // HOLD combine with a new local in the same cycle stays in HOLD
    vecs[17] = '{1'b0, 24'h0,      1'b1, 24'h000003, 1'b0, 1'b0, 1'b0, 24'h000029, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1, 24'h000004, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000029, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 24'h0,      1'b1, 24'h000050, 1'b1, 1'b0, 1'b1, 24'h000007, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 24'h000001, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h000007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 24'h000051, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // sfp_rd with an empty FIFO and no local word does nothing
    vecs[22] = '{1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 24'h000051, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle_in();
    reset = 1'b1;
    #22;
    // reset state
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full",  32'(fifo_full),  32'd0);
    chk("rst_credit",32'(rx_credit),  32'd0);
    chk("rst_total", 32'(sum_total),  32'd0);
    chk("rst_valid", 32'(sum_valid),  32'd0);
    chk("rst_ovf",   32'(ovf_err),    32'd0);
    chk("rst_state", 32'(dbg_state),  32'(NO_LOCAL));
    reset = 1'b0;
    #1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rv, vecs[i].d, vecs[i].lv, vecs[i].ls, vecs[i].rd, vecs[i].clr);
      cycle();
      chk($sformatf("v%0d_sum_valid", i), 32'(sum_valid),  32'(vecs[i].sv));
      chk($sformatf("v%0d_sum_total", i), 32'(sum_total),  32'(vecs[i].tot));
      chk($sformatf("v%0d_rx_credit", i), 32'(rx_credit),  32'(vecs[i].cr));
      chk($sformatf("v%0d_empty", i),     32'(fifo_empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d_full", i),      32'(fifo_full),  32'(vecs[i].full));
      chk($sformatf("v%0d_ovf", i),       32'(ovf_err),    32'(vecs[i].ovf));
      chk($sformatf("v%0d_state", i),     32'(dbg_state),  32'(vecs[i].st));
    end
    idle_in();

    // ---------------- full / simultaneous push+pop ----------------
    drive(1'b0, 24'h0, 1'b1, 24'h001000, 1'b0, 1'b0);
    cycle();
    chk("full_hold_state", 32'(dbg_state), 32'(HOLD));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 24'(32'hA0 + i), 1'b0, 24'h0, 1'b0, 1'b0);
      cycle();
    end
    chk("full_after8", 32'(fifo_full), 32'd1);
    chk("full_count8", 32'(dbg_count), 32'd8);
    drive(1'b1, 24'h0000A8, 1'b0, 24'h0, 1'b1, 1'b0);
    cycle();
    chk("push9_total", 32'(sum_total), 32'h10A0);
    chk("push9_valid", 32'(sum_valid), 32'd1);
    chk("push9_count", 32'(dbg_count), 32'd8);
    chk("push9_ovf",   32'(ovf_err),   32'd0);
    chk("push9_state", 32'(dbg_state), 32'(NO_LOCAL));
    drive(1'b1, 24'h0000BB, 1'b0, 24'h0, 1'b0, 1'b0);
    cycle();
    chk("push10_ovf",   32'(ovf_err),   32'd1);
    chk("push10_count", 32'(dbg_count), 32'd8);
    drive(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b1);
    cycle();
    chk("clr_ovf", 32'(ovf_err), 32'd0);
    // the FIFO still holds A1..A8, and the dropped BB must not appear
    for (int i = 1; i <= 8; i++) exp_q.push_back(24'(32'hA0 + i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 24'h0, 1'b1, 24'h0, 1'b1, 1'b0);
      cycle();
      chk($sformatf("drain%0d_total", i), 32'(sum_total), 32'(exp_q.pop_front()));
      chk($sformatf("drain%0d_credit", i), 32'(rx_credit), 32'd1);
    end
    idle_in();
    cycle();
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // ---------------- wrap-around ----------------
    credits = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 24'(i), 1'b0, 24'h0, 1'b0, 1'b0);
      exp_q.push_back(24'(i));
      cycle();
      drive(1'b0, 24'h0, 1'b1, 24'h0, 1'b1, 1'b0);
      cycle();
      chk($sformatf("wrap%0d_valid", i), 32'(sum_valid), 32'd1);
      chk($sformatf("wrap%0d_total", i), 32'(sum_total), 32'(exp_q.pop_front()));
    end
    idle_in();
    cycle();
    chk("wrap_credits", 32'(credits), 32'd20);
    chk("wrap_empty",   32'(fifo_empty), 32'd1);

    // ---------------- reset mid-operation ----------------
    drive(1'b1, 24'h000031, 1'b1, 24'h000077, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'h000032, 1'b0, 24'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 24'h000033, 1'b1, 24'h000078, 1'b0, 1'b0);
    cycle();
    idle_in();
    chk("pre_rst_count", 32'(dbg_count), 32'd3);
    chk("pre_rst_ovf",   32'(ovf_err),   32'd1);
    chk("pre_rst_state", 32'(dbg_state), 32'(HOLD));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    chk("mid_rst_valid", 32'(sum_valid),  32'd0);
    chk("mid_rst_state", 32'(dbg_state),  32'(NO_LOCAL));
    chk("mid_rst_ovf",   32'(ovf_err),    32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    drive(1'b1, 24'h000010, 1'b0, 24'h0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 24'h0, 1'b1, 24'h000005, 1'b1, 1'b0);
    cycle();
    chk("post_rst_valid",  32'(sum_valid), 32'd1);
    chk("post_rst_total",  32'(sum_total), 32'h15);
    chk("post_rst_credit", 32'(rx_credit), 32'd1);
    chk("post_rst_state",  32'(dbg_state), 32'(NO_LOCAL));
    chk("post_rst_empty",  32'(fifo_empty), 32'd1);
    // a clear in the same cycle as a new error leaves the error set
    drive(1'b0, 24'h0, 1'b1, 24'h000001, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 24'h0, 1'b1, 24'h000002, 1'b0, 1'b1);
    cycle();
    chk("set_beats_clr", 32'(ovf_err), 32'd1);
    idle_in();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
